// File: rtl/hrange_stream_if.sv
// hrange_stream_if: start/parameter inputs and the output stream of the
// hrange_stream range generator, bundled into one port.
// Optional feature macro: HRANGE_STREAM_INDEX_EN adds the _index ordinal.
//   master : the launcher/consumer side (drives _start, operands, _0_ready)
//   slave  : the generator side
interface hrange_stream_if #(
  parameter int WIDTH = 32
);
  logic                    _start;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic                    _0_ready;
  logic signed [WIDTH-1:0] _0;
  logic                    _valid;
  logic                    _ready;
  logic                    _busy;
`ifdef HRANGE_STREAM_INDEX_EN
  logic        [WIDTH-1:0] _index;
`endif

  modport master (
    output _start, base, limit, step, _0_ready,
`ifdef HRANGE_STREAM_INDEX_EN
    input  _index,
`endif
    input  _0, _valid, _ready, _busy
  );

  modport slave (
    input  _start, base, limit, step, _0_ready,
`ifdef HRANGE_STREAM_INDEX_EN
    output _index,
`endif
    output _0, _valid, _ready, _busy
  );
endinterface

// File: rtl/hrange_stream.sv
// hrange_stream: range iterator. After an accepted _start it streams
// base, base+step, ... while the value stays strictly on the base side of
// limit, honouring consumer backpressure, then pulses _ready for one cycle.
// Range tests use WIDTH+1 bit signed arithmetic, so a step that would wrap
// around the WIDTH-bit range terminates the sequence instead of emitting.
// Optional feature macro: HRANGE_STREAM_INDEX_EN adds the _index ordinal.
module hrange_stream #(
  parameter int WIDTH = 32
) (
  input  logic           _clock,
  input  logic           _reset,
  hrange_stream_if.slave s
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic signed [WIDTH:0] wide_t;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic signed [WIDTH-1:0] limit_q, limit_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic                    done_q, done_d;
`ifdef HRANGE_STREAM_INDEX_EN
  logic        [WIDTH-1:0] index_q, index_d;
`endif

  // Sign-extended operands: incoming ones for the launch test, latched
  // ones for the per-handshake test.
  wide_t in_base_w, in_limit_w, in_step_w;
  wide_t data_w, limit_w, step_w, nxt_w;

  assign in_base_w  = {s.base[WIDTH-1],  s.base};
  assign in_limit_w = {s.limit[WIDTH-1], s.limit};
  assign in_step_w  = {s.step[WIDTH-1],  s.step};
  assign data_w     = {data_q[WIDTH-1],  data_q};
  assign limit_w    = {limit_q[WIDTH-1], limit_q};
  assign step_w     = {step_q[WIDTH-1],  step_q};
  assign nxt_w      = data_w + step_w;

  // x lies strictly on the base side of lim for the direction of stp;
  // a zero step describes an empty sequence.
  function automatic logic in_range(input wide_t x, input wide_t lim,
                                    input wide_t stp);
    logic r;
    if (stp == '0) begin
      r = 1'b0;
    end else if (stp[WIDTH]) begin
      r = (x > lim);
    end else begin
      r = (x < lim);
    end
    return r;
  endfunction

  // Next-state logic: launch in IDLE, advance or finish on each handshake.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d = state_q;
    data_d  = data_q;
    limit_d = limit_q;
    step_d  = step_q;
    done_d  = 1'b0;
`ifdef HRANGE_STREAM_INDEX_EN
    index_d = index_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s._start) begin
          limit_d = s.limit;
          step_d  = s.step;
`ifdef HRANGE_STREAM_INDEX_EN
          index_d = '0;
`endif
          if (in_range(in_base_w, in_limit_w, in_step_w)) begin
            state_d = EMIT;
            data_d  = s.base;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // _start is deliberately not looked at here: no restart mid-run.
        if (s._0_ready) begin
          if (in_range(nxt_w, limit_w, step_w)) begin
            data_d = nxt_w[WIDTH-1:0];
`ifdef HRANGE_STREAM_INDEX_EN
            index_d = index_q + WIDTH'(1);
`endif
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge _clock or negedge _reset) begin
    // NOTE: these are individual flops rather than a memory array, so all
    // of them take the async reset; a mid-run reset clears everything.
    if (!_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop updates from the
      // values present before the edge regardless of statement order.
      state_q <= state_d;
      data_q  <= data_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

`ifdef HRANGE_STREAM_INDEX_EN
  // Ordinal of the element currently presented on _0.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign s._index = index_q;
`endif

  // _valid and _busy both mean "in EMIT"; _ready is the registered pulse
  // raised only on the transition into (or staying in) IDLE, so it can
  // never coincide with _valid.
  assign s._0     = data_q;
  assign s._valid = (state_q == EMIT);
  assign s._busy  = (state_q == EMIT);
  assign s._ready = done_q;

endmodule

// File: tb/tb_hrange_stream.sv
// tb_hrange_stream: randomized, self-checking bench for hrange_stream.
// The expected sequence of each run is computed as a plain list of
// mathematical integers (64-bit), then compared cycle by cycle against the
// stream while the consumer applies randomized or scripted backpressure.
// Optional feature macro: HRANGE_STREAM_INDEX_EN (also checks _index).
module tb_hrange_stream;

  logic _clock = 1'b0;
  logic _reset = 1'b0;
  always #5 _clock = ~_clock;

  hrange_stream_if #(.WIDTH(32)) bus ();
  hrange_stream_if #(.WIDTH(8))  bus8 ();

  hrange_stream #(.WIDTH(32)) dut (
    ._clock (_clock),
    ._reset (_reset),
    .s      (bus)
  );

  hrange_stream #(.WIDTH(8)) dut8 (
    ._clock (_clock),
    ._reset (_reset),
    .s      (bus8)
  );

  int total = 0;
  int bad   = 0;

  longint exp_q[$];

  // Expected elements: start at b, keep adding st while strictly on the
  // base side of l; a zero step yields nothing.
  task automatic build_exp(input longint b, input longint l, input longint st);
    longint x;
    exp_q.delete();
    x = b;
    if (st != 0) begin
      while ((st > 0) ? (x < l) : (x > l)) begin
        exp_q.push_back(x);
        x = x + st;
      end
    end
  endtask

  // Launch at the current negedge, then follow the stream in lockstep.
  // mode 0: always ready, 1: random ready, 2: ready low 3 cycles per element.
  // junk: toggle _start with random operands while the run is active.
  // Returns at the negedge where _ready is expected (start deasserted).
  task automatic run_seq(input longint b, input longint l, input longint st,
                         input int mode, input bit junk);
    int  n, hs, stall;
    bit  exp_v, exp_r, rdy, finished;
    build_exp(b, l, st);
    n  = exp_q.size();
    hs = 0;
    stall = 0;
    finished = 1'b0;
    bus._start = 1'b1;
    bus.base   = 32'(b);
    bus.limit  = 32'(l);
    bus.step   = 32'(st);
    @(negedge _clock);
    bus._start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      exp_v = (hs < n);
      exp_r = (hs == n);
      total++;
      if (bus._valid !== exp_v) begin
        bad++;
        $display("FAIL valid (b=%0d l=%0d s=%0d el=%0d): got %b want %b", b, l, st, hs, bus._valid, exp_v);
      end
      total++;
      if (bus._ready !== exp_r) begin
        bad++;
        $display("FAIL ready (b=%0d l=%0d s=%0d el=%0d): got %b want %b", b, l, st, hs, bus._ready, exp_r);
      end
      total++;
      if (bus._busy !== exp_v) begin
        bad++;
        $display("FAIL busy (b=%0d l=%0d s=%0d el=%0d): got %b want %b", b, l, st, hs, bus._busy, exp_v);
      end
      if (exp_v) begin
        total++;
        if (longint'(bus._0) !== exp_q[hs]) begin
          bad++;
          $display("FAIL data (b=%0d l=%0d s=%0d el=%0d): got %0d want %0d", b, l, st, hs, bus._0, exp_q[hs]);
        end
`ifdef HRANGE_STREAM_INDEX_EN
        total++;
        if (bus._index !== 32'(hs)) begin
          bad++;
          $display("FAIL index (b=%0d l=%0d s=%0d): got %0d want %0d", b, l, st, bus._index, hs);
        end
`endif
      end
      if (exp_r) begin
        finished = 1'b1;
        break;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (stall == 3) begin
            rdy = 1'b1;
            stall = 0;
          end else begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      bus._0_ready = rdy;
      if (junk) begin
        bus._start = 1'($urandom_range(0, 1));
        bus.base   = $urandom;
        bus.limit  = $urandom;
        bus.step   = $urandom;
      end
      if (exp_v && rdy) hs++;
      @(negedge _clock);
    end
    bus._start = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL timeout (b=%0d l=%0d s=%0d): reached el=%0d want %0d", b, l, st, hs, n);
    end
  endtask

  // One cycle after the _ready pulse: quiet outputs, _0 keeps last element.
  task automatic check_after(input string name);
    bus._start = 1'b0;
    @(negedge _clock);
    total++;
    if (bus._ready !== 1'b0 || bus._valid !== 1'b0 || bus._busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after: ready=%b valid=%b busy=%b want 0 0 0", name, bus._ready, bus._valid, bus._busy);
    end
    if (exp_q.size() > 0) begin
      total++;
      if (longint'(bus._0) !== exp_q[exp_q.size()-1]) begin
        bad++;
        $display("FAIL %s hold: got %0d want %0d", name, bus._0, exp_q[exp_q.size()-1]);
      end
    end
  endtask

  task automatic test_reset();
    bus._start = 1'b0; bus.base = '0; bus.limit = '0; bus.step = '0; bus._0_ready = 1'b0;
    bus8._start = 1'b0; bus8.base = '0; bus8.limit = '0; bus8.step = '0; bus8._0_ready = 1'b0;
    _reset = 1'b0;
    #7;
    total++;
    if (bus._0 !== 32'sd0 || bus._valid !== 1'b0 || bus._ready !== 1'b0 || bus._busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: _0=%0d valid=%b ready=%b busy=%b want 0 0 0 0", bus._0, bus._valid, bus._ready, bus._busy);
    end
`ifdef HRANGE_STREAM_INDEX_EN
    total++;
    if (bus._index !== '0) begin
      bad++;
      $display("FAIL reset index: got %0d want 0", bus._index);
    end
`endif
    @(negedge _clock);
    _reset = 1'b1;
    @(negedge _clock);
  endtask

  task automatic test_basic();
    run_seq(0, 5, 1, 0, 0);
    check_after("basic");
  endtask

  task automatic test_negative_step();
    run_seq(10, 0, -3, 0, 0);
    check_after("negstep");
  endtask

  task automatic test_empty();
    run_seq(3, 3, 1, 0, 0);
    check_after("empty_eq");
    run_seq(0, 9, 0, 0, 0);
    check_after("empty_zero_step");
    run_seq(5, 0, 1, 0, 0);
    check_after("empty_wrong_side");
  endtask

  task automatic test_backpressure();
    run_seq(0, 3, 1, 2, 0);
    check_after("backpressure");
    run_seq(-4, -40, -5, 1, 0);
    check_after("random_stall");
  endtask

  task automatic test_wrap32();
    run_seq(64'sh7FFF_FFF0, 64'sh7FFF_FFFF, 10, 0, 0);
    check_after("wrap_pos");
    run_seq(-64'sd2147483643, -64'sd2147483648, -4, 0, 0);
    check_after("wrap_neg");
  endtask

  task automatic test_start_during_emit();
    run_seq(0, 12, 2, 1, 1);
    check_after("start_in_emit");
  endtask

  task automatic test_back_to_back();
    run_seq(0, 3, 1, 0, 0);
    run_seq(20, 14, -2, 0, 0);
    run_seq(1, 1, 1, 0, 0);
    run_seq(7, 9, 1, 1, 0);
    check_after("back_to_back");
  endtask

  task automatic test_mid_reset();
    bus._start = 1'b1; bus.base = 32'sd0; bus.limit = 32'sd100; bus.step = 32'sd1;
    bus._0_ready = 1'b1;
    @(negedge _clock);
    bus._start = 1'b0;
    repeat (4) @(negedge _clock);
    total++;
    if (bus._valid !== 1'b1 || bus._0 !== 32'sd4) begin
      bad++;
      $display("FAIL midreset pre: valid=%b _0=%0d want 1 4", bus._valid, bus._0);
    end
    #2 _reset = 1'b0;
    #1;
    total++;
    if (bus._0 !== 32'sd0 || bus._valid !== 1'b0 || bus._ready !== 1'b0 || bus._busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset async: _0=%0d valid=%b ready=%b busy=%b want 0 0 0 0", bus._0, bus._valid, bus._ready, bus._busy);
    end
    @(negedge _clock);
    _reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge _clock);
      total++;
      if (bus._ready !== 1'b0 || bus._valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset quiet %0d: ready=%b valid=%b want 0 0", i, bus._ready, bus._valid);
      end
    end
    run_seq(4, 8, 1, 0, 0);
    check_after("after_reset");
  endtask

  // Same lockstep follow on the 8-bit instance, consumer always ready.
  task automatic run8(input longint b, input longint l, input longint st);
    int n, hs;
    bit exp_v, exp_r, finished;
    build_exp(b, l, st);
    n = exp_q.size();
    hs = 0;
    finished = 1'b0;
    bus8._start = 1'b1; bus8.base = 8'(b); bus8.limit = 8'(l); bus8.step = 8'(st);
    bus8._0_ready = 1'b1;
    @(negedge _clock);
    bus8._start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_v = (hs < n);
      exp_r = (hs == n);
      total++;
      if (bus8._valid !== exp_v || bus8._ready !== exp_r) begin
        bad++;
        $display("FAIL w8 ctl (b=%0d l=%0d s=%0d el=%0d): valid=%b ready=%b want %b %b", b, l, st, hs, bus8._valid, bus8._ready, exp_v, exp_r);
      end
      if (exp_v) begin
        total++;
        if (longint'(bus8._0) !== exp_q[hs]) begin
          bad++;
          $display("FAIL w8 data (b=%0d l=%0d s=%0d el=%0d): got %0d want %0d", b, l, st, hs, bus8._0, exp_q[hs]);
        end
      end
      if (exp_r) begin
        finished = 1'b1;
        break;
      end
      hs++;
      @(negedge _clock);
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL w8 timeout (b=%0d l=%0d s=%0d): el=%0d want %0d", b, l, st, hs, n);
    end
    @(negedge _clock);
    total++;
    if (bus8._ready !== 1'b0 || bus8._valid !== 1'b0) begin
      bad++;
      $display("FAIL w8 after: ready=%b valid=%b want 0 0", bus8._ready, bus8._valid);
    end
  endtask

  task automatic test_width8();
    run8(125, 127, 5);
    run8(-126, -128, -4);
    run8(120, 127, 3);
    run8(-100, 127, 60);
    for (int i = 0; i < 6; i++) begin
      run8(longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 255)) - 128,
           longint'($urandom_range(0, 120)) - 60);
    end
  endtask

  task automatic test_random();
    longint b, l, st;
    for (int i = 0; i < 25; i++) begin
      b  = longint'($urandom_range(0, 200)) - 100;
      st = longint'($urandom_range(0, 14)) - 7;
      l  = b + st * longint'($urandom_range(0, 8)) + longint'($urandom_range(0, 4)) - 2;
      run_seq(b, l, st, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) check_after("random");
    end
    check_after("random_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_step();
    test_empty();
    test_backpressure();
    test_wrap32();
    test_start_during_emit();
    test_back_to_back();
    test_mid_reset();
    test_width8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
